// File: rtl/tcs3200_emulator.sv
// rtl/tcs3200_emulator.sv - TCS3200 colour sensor emulator producing a programmable square wave
module tcs3200_emulator #(
  parameter int PERIOD_W  = 16,
  parameter int DEF_RED   = 100,
  parameter int DEF_GREEN = 150,
  parameter int DEF_BLUE  = 200,
  parameter int DEF_WHITE = 120
) (
  input  logic                scaled_clock,
  input  logic                reset_n,
  input  logic                cs_S0,
  input  logic                cs_S1,
  input  logic                cs_S2,
  input  logic                cs_S3,
  input  logic                cs_en,
  input  logic                cfg_wr,
  input  logic [1:0]          cfg_sel,
  input  logic [PERIOD_W-1:0] cfg_data,
  output logic                cs_output,
  output logic [15:0]         edge_cnt
);

  localparam int PW = PERIOD_W + 6;

  typedef enum logic {IDLE, RUN} state_t;

  // Synchronizer bit order: {S0, S1, S2, S3, en}
  logic [4:0]          sync1, sync2;
  logic [3:0]          sel_prev;
  logic [PERIOD_W-1:0] base [4];
  logic [PERIOD_W-1:0] base_eff;
  logic [1:0]          chan;
  logic [1:0]          scale_s;
  logic                active;
  logic                restart;
  logic [PW-1:0]       mult;
  logic [PW-1:0]       p_raw;
  logic [PW-1:0]       p_calc;
  logic [PW-1:0]       p_lat;
  logic [PW-1:0]       l_cur;
  logic [PW-1:0]       cnt;
  logic [PW-1:0]       cnt_inc;
  state_t              state;

  // Two-flop synchronizers for the sensor control pins, plus last select for change detection
  always_ff @(posedge scaled_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      sel_prev <= '0;
    end else begin
      sync1    <= {cs_S0, cs_S1, cs_S2, cs_S3, cs_en};
      sync2    <= sync1;
      sel_prev <= sync2[4:1];
    end
  end

  // Per-channel base period registers
  always_ff @(posedge scaled_clock or negedge reset_n) begin
    if (!reset_n) begin
      base[0] <= PERIOD_W'(DEF_RED);
      base[1] <= PERIOD_W'(DEF_GREEN);
      base[2] <= PERIOD_W'(DEF_BLUE);
      base[3] <= PERIOD_W'(DEF_WHITE);
    end else if (cfg_wr) begin
      base[cfg_sel] <= cfg_data;
    end
  end

  // Effective period from synchronized selects; a same-cycle write to the active channel is forwarded
  always_comb begin
    scale_s = sync2[4:3];
    case (sync2[2:1])
      2'b00:   chan = 2'd0;
      2'b11:   chan = 2'd1;
      2'b01:   chan = 2'd2;
      default: chan = 2'd3;
    endcase
    base_eff = (cfg_wr && (cfg_sel == chan)) ? cfg_data : base[chan];
    case (scale_s)
      2'b11:   mult = PW'(1);
      2'b10:   mult = PW'(5);
      2'b01:   mult = PW'(50);
      default: mult = PW'(0);
    endcase
    p_raw   = PW'(base_eff) * mult;
    p_calc  = (p_raw < PW'(2)) ? PW'(2) : p_raw;
    active  = !sync2[0] && (scale_s != 2'b00);
    restart = active && ((state == IDLE) || (sync2[4:1] != sel_prev));
    l_cur   = p_lat - (p_lat >> 1);
    cnt_inc = cnt + PW'(1);
  end

  // Output FSM: idle hold, restart, period boundary re-latch, and phase generation
  always_ff @(posedge scaled_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      p_lat     <= PW'(2);
      cs_output <= 1'b0;
      edge_cnt  <= '0;
    end else if (!active) begin
      state     <= IDLE;
      cnt       <= '0;
      cs_output <= 1'b0;
    end else if (restart) begin
      state     <= RUN;
      cnt       <= '0;
      p_lat     <= p_calc;
      cs_output <= 1'b0;
    end else if (cnt == p_lat - PW'(1)) begin
      cnt       <= '0;
      p_lat     <= p_calc;
      cs_output <= 1'b0;
    end else begin
      cnt       <= cnt_inc;
      cs_output <= (cnt_inc >= l_cur);
      if (!cs_output && (cnt_inc >= l_cur)) begin
        edge_cnt <= edge_cnt + 16'd1;
      end
    end
  end

endmodule
